// File: rtl/display_scheduler_if.sv
// Bus between the display scheduler and its sources/display decoder.
// The slave modport is the scheduler side; the master modport is the driver side.
interface display_scheduler_if;
  logic [23:0] src_val;
  logic [3:0]  src_en;
  // Request/grant: urgent_req[i] is a one-cycle pulse that latches a pending
  // request; urgent_ack[i] is a one-cycle pulse in the first cycle of the
  // granted slot. Requests are never dropped, only deferred while pinned or
  // while another urgent slot is running.
  logic [3:0]  urgent_req;
  logic        pin_req;
  logic [1:0]  pin_sel;
  logic [5:0]  num_out;
  logic [1:0]  cur_src;
  logic        slot_start;
  logic [3:0]  urgent_ack;
  logic [1:0]  state_dbg;

  modport slave (
    input  src_val, src_en, urgent_req, pin_req, pin_sel,
    output num_out, cur_src, slot_start, urgent_ack, state_dbg
  );

  modport master (
    output src_val, src_en, urgent_req, pin_req, pin_sel,
    input  num_out, cur_src, slot_start, urgent_ack, state_dbg
  );
endinterface

// File: rtl/display_scheduler.sv
// Time-multiplexes four 6-bit sources onto the hex display: round-robin rotation,
// urgent preemption and pin freeze. Define DISP_BLINK_EN to add the blink 'blank' output.
module display_scheduler #(
  parameter int DWELL = 50_000_000,
  parameter int CNT_W = 26
) (
  input  logic clk,
  input  logic rst_n,
  display_scheduler_if.slave bus
`ifdef DISP_BLINK_EN
  ,
  output logic blank
`endif
);

  typedef enum logic [1:0] {IDLE, ROTATE, URGENT, PIN} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  state_t           state_q, state_d;
  logic [1:0]       cur_src_q, cur_src_d;
  logic [1:0]       resume_q, resume_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       pending_q, pending_d;
  logic [3:0]       urgent_ack_q, urgent_ack_d;
  logic             slot_start_q, slot_start_d;
  logic [5:0]       num_out_q, num_out_d;
  logic             grant;
  logic [1:0]       pend_idx;

  // First set bit of mask strictly after 'from', wrapping; 'from' itself is
  // checked last so a lone enabled source restarts on itself.
  function automatic logic [1:0] next_idx(input logic [1:0] from, input logic [3:0] mask);
    logic [1:0] r;
    logic [1:0] j;
    r = from;
    for (int k = 4; k >= 1; k--) begin
      j = from + 2'(k);
      if (mask[j]) r = j;
    end
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    cur_src_d    = cur_src_q;
    cnt_d        = cnt_q;
    resume_d     = resume_q;
    slot_start_d = 1'b0;
    urgent_ack_d = '0;
    grant        = 1'b0;
    pend_idx     = next_idx(2'd3, pending_q);

    if (bus.pin_req) begin
      slot_start_d = (state_q != PIN) || (bus.pin_sel != cur_src_q);
      state_d      = PIN;
      cur_src_d    = bus.pin_sel;
      cnt_d        = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|pending_q) begin
            grant    = 1'b1;
            resume_d = 2'd3;
          end else if (|bus.src_en) begin
            state_d      = ROTATE;
            cur_src_d    = next_idx(2'd3, bus.src_en);
            cnt_d        = '0;
            slot_start_d = 1'b1;
          end
        end
        ROTATE: begin
          if (|pending_q) begin
            grant    = 1'b1;
            resume_d = cur_src_q;
          end else if (bus.src_en == 4'd0) begin
            state_d   = IDLE;
            cur_src_d = 2'd0;
            cnt_d     = '0;
          end else if (!bus.src_en[cur_src_q] || cnt_q == LAST) begin
            cur_src_d    = next_idx(cur_src_q, bus.src_en);
            cnt_d        = '0;
            slot_start_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        URGENT: begin
          if (cnt_q != LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else if (|pending_q) begin
            grant = 1'b1;
          end else if (|bus.src_en) begin
            state_d      = ROTATE;
            cur_src_d    = next_idx(resume_q, bus.src_en);
            cnt_d        = '0;
            slot_start_d = 1'b1;
          end else begin
            state_d   = IDLE;
            cur_src_d = 2'd0;
            cnt_d     = '0;
          end
        end
        PIN: begin
          if (|pending_q) begin
            grant    = 1'b1;
            resume_d = cur_src_q;
          end else if (|bus.src_en) begin
            // Starting the search one below resumes on the pinned source if enabled.
            state_d      = ROTATE;
            cur_src_d    = next_idx(cur_src_q - 2'd1, bus.src_en);
            cnt_d        = '0;
            slot_start_d = 1'b1;
          end else begin
            state_d   = IDLE;
            cur_src_d = 2'd0;
            cnt_d     = '0;
          end
        end
        default: begin
          state_d   = IDLE;
          cur_src_d = 2'd0;
          cnt_d     = '0;
        end
      endcase

      if (grant) begin
        state_d                = URGENT;
        cur_src_d              = pend_idx;
        cnt_d                  = '0;
        slot_start_d           = 1'b1;
        urgent_ack_d[pend_idx] = 1'b1;
      end
    end

    // A new request on the bit being granted this cycle survives the clear.
    pending_d = (pending_q & ~urgent_ack_d) | bus.urgent_req;
    num_out_d = (state_d == IDLE) ? 6'd0 : bus.src_val[6*int'(cur_src_d) +: 6];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cur_src_q    <= 2'd0;
      resume_q     <= 2'd0;
      cnt_q        <= '0;
      pending_q    <= 4'd0;
      urgent_ack_q <= 4'd0;
      slot_start_q <= 1'b0;
      num_out_q    <= 6'd0;
    end else begin
      state_q      <= state_d;
      cur_src_q    <= cur_src_d;
      resume_q     <= resume_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      urgent_ack_q <= urgent_ack_d;
      slot_start_q <= slot_start_d;
      num_out_q    <= num_out_d;
    end
  end

  assign bus.num_out    = num_out_q;
  assign bus.cur_src    = cur_src_q;
  assign bus.slot_start = slot_start_q;
  assign bus.urgent_ack = urgent_ack_q;
  assign bus.state_dbg  = state_q;

`ifdef DISP_BLINK_EN
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'((DWELL >> 3) - 1);

  logic             blank_q, blank_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;

  // Each urgent slot starts unblanked and toggles every DWELL/8 cycles.
  always_comb begin
    blank_d     = 1'b0;
    blink_cnt_d = '0;
    if (state_d == IDLE) begin
      blank_d = 1'b1;
    end else if (state_d == URGENT && !grant) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blank_d = ~blank_q;
      end else begin
        blank_d     = blank_q;
        blink_cnt_d = blink_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blank_q     <= 1'b1;
      blink_cnt_q <= '0;
    end else begin
      blank_q     <= blank_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign blank = blank_q;
`endif

endmodule
